// File: rtl/apb_uart_rx.sv
// APB slave 8N1 UART receiver with a small receive FIFO, polled through DATA/STATUS registers.
// Define APB_UART_RX_PARITY_EN to receive 8E1 frames and report parity errors in STATUS bit4.
module apb_uart_rx #(
   parameter int BUS_WIDTH    = 16,
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] S_PADDR,
   input  logic                 S_PWRITE,
   input  logic                 S_PSELx,
   input  logic                 S_PENABLE,
   input  logic [BUS_WIDTH-1:0] S_PWDATA,
   output logic [BUS_WIDTH-1:0] S_PRDATA,
   output logic                 S_PREADY,
   input  logic                 rx_wire,
   output logic                 rx_irq
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   DEPTH_CT = (AW + 1)'(FIFO_DEPTH);

`ifdef APB_UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
`endif

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            push_q, push_d;
   logic            sync1_q, rxs_q;
   logic            ferr_set, perr_set;
   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic            ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
   logic            irq_q;
   logic            access, rd_acc, wr_acc, clr, not_empty, full, pop, push_ok, ovr_set;
   logic [7:0]      status, head;

   function automatic logic [2:0] sat3(input logic [AW:0] c);
      logic [31:0] w;
      w = 32'(c);
      if (w > 32'd7) return 3'd7;
      return w[2:0];
   endfunction

   // Receive FSM: all sampling uses the synchronised line rxs_q
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      push_d   = 1'b0;
      ferr_set = 1'b0;
      perr_set = 1'b0;
      case (state_q)
         S_IDLE: if (!rxs_q) begin
            state_d = S_START;
            cnt_d   = '0;
            bit_d   = '0;
         end
         S_START: if (cnt_q == HALF_M1) begin
            cnt_d   = '0;
            state_d = rxs_q ? S_IDLE : S_DATA;
         end else cnt_d = cnt_q + CW'(1);
         S_DATA: if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            shift_d = {rxs_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
`ifdef APB_UART_RX_PARITY_EN
            if (bit_q == 3'd7) state_d = S_PARITY;
`else
            if (bit_q == 3'd7) state_d = S_STOP;
`endif
         end else cnt_d = cnt_q + CW'(1);
`ifdef APB_UART_RX_PARITY_EN
         S_PARITY: if (cnt_q == FULL_M1) begin
            cnt_d    = '0;
            perr_set = rxs_q != (^shift_q);
            state_d  = S_STOP;
         end else cnt_d = cnt_q + CW'(1);
`endif
         S_STOP: if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            if (rxs_q) begin
               push_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               ferr_set = 1'b1;
               state_d  = S_WAIT_HIGH;
            end
         end else cnt_d = cnt_q + CW'(1);
         S_WAIT_HIGH: if (rxs_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // APB decode, FIFO pointers and sticky flags
   always_comb begin
      access    = S_PSELx & S_PENABLE;
      rd_acc    = access & ~S_PWRITE;
      wr_acc    = access & S_PWRITE;
      clr       = wr_acc & S_PADDR[0];
      not_empty = count_q != '0;
      full      = count_q == DEPTH_CT;
      pop       = rd_acc & ~S_PADDR[0] & not_empty;
      push_ok   = push_q & (~full | pop);
      ovr_set   = push_q & full & ~pop;
      wr_ptr_d  = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d   = count_q;
      if (push_ok && !pop) count_d = count_q + (AW + 1)'(1);
      if (pop && !push_ok) count_d = count_q - (AW + 1)'(1);
      ovr_d  = ovr_set  | (ovr_q  & ~(clr & S_PWDATA[2]));
      ferr_d = ferr_set | (ferr_q & ~(clr & S_PWDATA[3]));
`ifdef APB_UART_RX_PARITY_EN
      perr_d = perr_set | (perr_q & ~(clr & S_PWDATA[4]));
`else
      perr_d = 1'b0;
`endif
      head     = not_empty ? mem_q[rd_ptr_q] : 8'h00;
      status   = {sat3(count_q), perr_q, ferr_q, ovr_q, full, not_empty};
      S_PREADY = access;
      S_PRDATA = '0;
      if (access) S_PRDATA = BUS_WIDTH'(S_PADDR[0] ? status : head);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         push_q   <= 1'b0;
         sync1_q  <= 1'b1;
         rxs_q    <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         push_q   <= push_d;
         sync1_q  <= rx_wire;
         rxs_q    <= sync1_q;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovr_q    <= ovr_d;
         ferr_q   <= ferr_d;
         perr_q   <= perr_d;
         irq_q    <= count_d != '0;
      end
   end

   // Data path: the shift register is held until the push one cycle after the stop sample
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
      if (push_ok) mem_q[wr_ptr_q] <= shift_q;
   end

   assign rx_irq = irq_q;

   logic unused_bits;
`ifdef APB_UART_RX_PARITY_EN
   assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA[BUS_WIDTH-1:5], S_PWDATA[1:0]};
`else
   assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA[BUS_WIDTH-1:4], S_PWDATA[1:0], perr_set};
`endif
endmodule

// File: tb/tb_apb_uart_rx.sv
// Directed bench for apb_uart_rx at 8 clocks per bit with a 4-entry FIFO.
// Frames are driven on rx_wire at falling edges; APB reads are sampled just after the access-phase falling edge.
module tb_apb_uart_rx;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] S_PADDR;
   logic        S_PWRITE;
   logic        S_PSELx;
   logic        S_PENABLE;
   logic [15:0] S_PWDATA;
   logic [15:0] S_PRDATA;
   logic        S_PREADY;
   logic        rx_wire;
   logic        rx_irq;

   int checks = 0;
   int errors = 0;
   logic [15:0] rd;

   apb_uart_rx #(.BUS_WIDTH(16), .CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
      .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA),
      .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .rx_wire(rx_wire), .rx_irq(rx_irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the line at the stop value so a broken stop bit can be extended by the caller
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
      rx_wire = 1'b0;
      cycles(8);
      for (int i = 0; i < 8; i++) begin
         rx_wire = b[i];
         cycles(8);
      end
`ifdef APB_UART_RX_PARITY_EN
      rx_wire = par;
      cycles(8);
`endif
      rx_wire = stop;
      cycles(8);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, ^b, 1'b1);
   endtask

   task automatic apb_read(input logic addr, output logic [15:0] data);
      S_PADDR   = {15'd0, addr};
      S_PWRITE  = 1'b0;
      S_PSELx   = 1'b1;
      S_PENABLE = 1'b0;
      cycles(1);
      S_PENABLE = 1'b1;
      #1 data = S_PRDATA;
      cycles(1);
      S_PSELx   = 1'b0;
      S_PENABLE = 1'b0;
   endtask

   task automatic apb_write(input logic addr, input logic [15:0] data);
      S_PADDR   = {15'd0, addr};
      S_PWRITE  = 1'b1;
      S_PWDATA  = data;
      S_PSELx   = 1'b1;
      S_PENABLE = 1'b0;
      cycles(1);
      S_PENABLE = 1'b1;
      cycles(1);
      S_PSELx   = 1'b0;
      S_PENABLE = 1'b0;
      S_PWRITE  = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      rx_wire = 1'b1;
      S_PADDR = '0;
      S_PWRITE = 1'b0;
      S_PSELx = 1'b0;
      S_PENABLE = 1'b0;
      S_PWDATA = '0;
      cycles(3);
      #1;
      check("reset_prdata", 32'(S_PRDATA), 32'h0);
      check("reset_pready", 32'(S_PREADY), 32'h0);
      check("reset_irq", 32'(rx_irq), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      cycles(5);
      apb_read(1'b1, rd);
      check("idle_status", 32'(rd), 32'h0000);

      // single byte
      send_byte(8'hA5);
      cycles(6);
      #1;
      check("unselected_prdata", 32'(S_PRDATA), 32'h0);
      check("a5_irq", 32'(rx_irq), 32'h1);
      @(negedge clk);
      S_PADDR = 16'h0001; S_PWRITE = 1'b0; S_PSELx = 1'b1; S_PENABLE = 1'b0;
      cycles(1);
      S_PENABLE = 1'b1;
      #1;
      check("access_pready", 32'(S_PREADY), 32'h1);
      check("a5_status", 32'(S_PRDATA), 32'h0021);
      cycles(1);
      S_PSELx = 1'b0; S_PENABLE = 1'b0;
      apb_read(1'b0, rd);
      check("a5_data", 32'(rd), 32'h00A5);
      apb_read(1'b1, rd);
      check("a5_status_after", 32'(rd), 32'h0000);
      #1;
      check("a5_irq_after", 32'(rx_irq), 32'h0);
      @(negedge clk);

      // overrun: five bytes into a four-entry FIFO
      for (int i = 1; i <= 5; i++) send_byte(8'(i));
      cycles(6);
      apb_read(1'b1, rd);
      check("ovr_status", 32'(rd), 32'h0087);
      for (int i = 1; i <= 4; i++) begin
         apb_read(1'b0, rd);
         check($sformatf("ovr_data%0d", i), 32'(rd), 32'(i));
      end
      apb_read(1'b0, rd);
      check("empty_data", 32'(rd), 32'h0000);
      apb_write(1'b1, 16'h0004);
      apb_read(1'b1, rd);
      check("ovr_cleared", 32'(rd), 32'h0000);
      apb_write(1'b0, 16'h00FF);
      apb_read(1'b1, rd);
      check("data_write_ignored", 32'(rd), 32'h0000);

      // framing error then a good byte
      send_frame(8'h3C, ^8'h3C, 1'b0);
      cycles(40);
      rx_wire = 1'b1;
      cycles(16);
      send_byte(8'h7E);
      cycles(6);
      apb_read(1'b1, rd);
      check("ferr_status", 32'(rd), 32'h0029);
      apb_read(1'b0, rd);
      check("ferr_data", 32'(rd), 32'h007E);
      apb_read(1'b1, rd);
      check("ferr_only_one", 32'(rd), 32'h0008);
      apb_write(1'b1, 16'h001C);
      apb_read(1'b1, rd);
      check("ferr_cleared", 32'(rd), 32'h0000);

      // short low glitch
      rx_wire = 1'b0;
      cycles(3);
      rx_wire = 1'b1;
      cycles(30);
      apb_read(1'b1, rd);
      check("glitch_status", 32'(rd), 32'h0000);
      check("glitch_irq", 32'(rx_irq), 32'h0);

      // reset during bit 4 of a 0xC3 frame
      rx_wire = 1'b0;
      cycles(8);
      for (int i = 0; i < 4; i++) begin
         rx_wire = (i < 2);
         cycles(8);
      end
      rx_wire = 1'b0;
      cycles(4);
      reset = 1'b0;
      #1;
      check("midreset_irq", 32'(rx_irq), 32'h0);
      @(negedge clk);
      rx_wire = 1'b1;
      cycles(2);
      reset = 1'b1;
      cycles(20);
      apb_read(1'b1, rd);
      check("midreset_status", 32'(rd), 32'h0000);
      send_byte(8'h5A);
      cycles(6);
      apb_read(1'b1, rd);
      check("post_reset_status", 32'(rd), 32'h0021);
      apb_read(1'b0, rd);
      check("post_reset_data", 32'(rd), 32'h005A);
      apb_read(1'b1, rd);
      check("post_reset_empty", 32'(rd), 32'h0000);

`ifdef APB_UART_RX_PARITY_EN
      send_frame(8'h03, 1'b1, 1'b1);
      cycles(6);
      apb_read(1'b1, rd);
      check("perr_status", 32'(rd), 32'h0031);
      apb_read(1'b0, rd);
      check("perr_data", 32'(rd), 32'h0003);
      apb_write(1'b1, 16'h0010);
      send_frame(8'h03, 1'b0, 1'b1);
      cycles(6);
      apb_read(1'b1, rd);
      check("par_ok_status", 32'(rd), 32'h0021);
      apb_read(1'b0, rd);
      check("par_ok_data", 32'(rd), 32'h0003);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
